frame_write_sequencer: RTL and testbench
========================================

# frame_write_sequencer

Write-side sequencer for the ping-pong frame buffer. Accepts a valid/ready pixel stream with start-of-frame marking and turns it into raster write coordinates, pixel and write strobe. When a frame completes it waits for the display side's end-of-frame and then issues the one-cycle bank-swap pulse, so banks are never swapped mid-scanout. It sits between the camera/renderer pixel source and the dual-bank RAM controller, all in the write clock domain.

## Interface
- COOR_WIDTH, 12, width of coordinate outputs
- HSIZE, 720, pixels per line
- VSIZE, 540, lines per frame
- clk  input  1  write-domain clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pix_valid  input  1  source has a pixel
- pix_data  input  12  RGB444 pixel
- pix_sof  input  1  qualifies pixel as first of a frame (valid only with pix_valid)
- pix_ready  output  1  sequencer accepts pixel this cycle
- read_frame_end  input  1  one-cycle pulse, display side finished a frame (already synchronised to clk)
- write_x  output  COOR_WIDTH  column of written pixel
- write_y  output  COOR_WIDTH  row of written pixel
- write_pixel  output  12  pixel to write
- write_en  output  1  write strobe for write_x/write_y/write_pixel
- write_finished  output  1  one-cycle bank-swap pulse
- frame_cnt  output  16  committed frames, wraps
- err_cnt  output  8  short frames (sof before completion), saturates at 255
- drop_cnt  output  8  frames discarded while waiting to swap, saturates at 255

## Operation
- Accept = pix_valid && pix_ready.
- States: IDLE, WRITE, SWAP_WAIT.
- IDLE: pix_ready=1. Accepted pixels without pix_sof are discarded. An accepted pixel with pix_sof is written at (0,0). The FSM then goes to WRITE, or straight to SWAP_WAIT if HSIZE*VSIZE==1.
- WRITE: pix_ready=1. Each accepted pixel is written at the internal (x,y). x increments; at x==HSIZE-1, x wraps to 0 and y increments.
- Last pixel in WRITE: the accept at (HSIZE-1,VSIZE-1) writes the pixel and enters SWAP_WAIT.
- pix_sof accepted in WRITE (not at (0,0)): err_cnt++. The pixel is written at (0,0) and counting restarts from (1,0). No swap occurs.
- SWAP_WAIT: on read_frame_end, pulse write_finished, frame_cnt++, go to IDLE.
- A read_frame_end in the same cycle as the last-pixel accept counts: the swap fires on the next cycle.
- pix_data is never modified; write_pixel equals the accepted pix_data.
- Internal x/y are COOR_WIDTH bits; no bound beyond HSIZE/VSIZE.

## Timing
- Reset values: pix_ready=0, write_x=0, write_y=0, write_pixel=0, write_en=0, write_finished=0, all counters 0, state IDLE.
- pix_ready is combinational from state and is 1 in IDLE from the first clock after reset release.
- Write latency: write_en/write_x/write_y/write_pixel are registered and asserted the cycle after the accept, for exactly one cycle per accepted written pixel.
- write_finished is registered, high exactly one cycle, and always after the final write_en of the frame.
- Swap latency: write_finished rises the cycle after read_frame_end is sampled in SWAP_WAIT.
- Reset mid-frame: all state clears immediately (asynchronous). The partial frame is abandoned with no write_finished and no counter change.

## Configuration
- FRAME_DROP_EN defined:
  - SWAP_WAIT keeps pix_ready=1 and discards incoming pixels.
  - Each accepted pix_sof in SWAP_WAIT increments drop_cnt.
  - After the swap, the FSM waits in IDLE for the next sof.
- FRAME_DROP_EN undefined:
  - SWAP_WAIT holds pix_ready=0, back-pressuring the source.
  - drop_cnt is tied to 0.

## Test plan
Bench uses HSIZE=4, VSIZE=3.
- Reset, then 12 continuous valid pixels 0x001..0x00C with sof on the first -> 12 write_en pulses; coordinates (0,0)..(3,2) in raster order; pixel equals input; state SWAP_WAIT.
- Pulse read_frame_end 5 cycles after the last pixel -> write_finished high exactly one cycle, the cycle after; frame_cnt=1; back in IDLE.
- 3 pixels without sof in IDLE -> no write_en. Then sof frame with pix_valid toggling every other cycle -> 12 writes with correct coordinates.
- Sof, 6 pixels, second sof -> err_cnt=1; next write at (0,0); 12 more pixels complete the frame with no write_finished before read_frame_end.
- Complete frame, no read_frame_end, source presents a new sof frame:
  - Without FRAME_DROP_EN: pix_ready=0, no writes.
  - With FRAME_DROP_EN: pixels absorbed, drop_cnt=1, no writes.
- Drive rst_n low at pixel 7 -> outputs return to reset values immediately. A subsequent full frame writes from (0,0) and err_cnt stays 0.

Source files
------------

// File: rtl/frame_write_sequencer.sv
// Write-side sequencer for the ping-pong frame buffer: pixel stream in, raster writes and
// bank-swap pulse out. Optional macro FRAME_DROP_EN absorbs frames that arrive while waiting to swap.
module frame_write_sequencer #(
  parameter int unsigned COOR_WIDTH = 12,
  parameter int unsigned HSIZE      = 720,
  parameter int unsigned VSIZE      = 540
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic [11:0]           pix_data,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  input  logic                  read_frame_end,
  output logic [COOR_WIDTH-1:0] write_x,
  output logic [COOR_WIDTH-1:0] write_y,
  output logic [11:0]           write_pixel,
  output logic                  write_en,
  output logic                  write_finished,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            err_cnt,
  output logic [7:0]            drop_cnt
);

  typedef enum logic [1:0] {StIdle, StWrite, StSwapWait} state_e;

  localparam logic [COOR_WIDTH-1:0] XLast = COOR_WIDTH'(HSIZE - 1);
  localparam logic [COOR_WIDTH-1:0] YLast = COOR_WIDTH'(VSIZE - 1);
  localparam bit SinglePixel = (HSIZE * VSIZE == 1);
  // Position following (0,0); a one-pixel-wide line wraps straight to the next row.
  localparam logic [COOR_WIDTH-1:0] XAfterOrigin = COOR_WIDTH'((HSIZE == 1) ? 0 : 1);
  localparam logic [COOR_WIDTH-1:0] YAfterOrigin = COOR_WIDTH'((HSIZE == 1) ? 1 : 0);

  state_e                state_q;
  logic                  started_q;
  logic                  rfe_pending_q;
  logic [COOR_WIDTH-1:0] x_q;
  logic [COOR_WIDTH-1:0] y_q;
  logic [COOR_WIDTH-1:0] x_adv;
  logic [COOR_WIDTH-1:0] y_adv;
  logic                  accept;
  logic                  at_origin;
  logic                  at_last;

`ifdef FRAME_DROP_EN
  assign pix_ready = started_q;
`else
  assign pix_ready = started_q && (state_q != StSwapWait);
`endif

  assign accept = pix_valid && pix_ready;

  always_comb begin
    at_origin = (x_q == '0) && (y_q == '0);
    at_last   = (x_q == XLast) && (y_q == YLast);
    if (x_q == XLast) begin
      x_adv = '0;
      y_adv = y_q + COOR_WIDTH'(1);
    end else begin
      x_adv = x_q + COOR_WIDTH'(1);
      y_adv = y_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      started_q      <= 1'b0;
      rfe_pending_q  <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      write_x        <= '0;
      write_y        <= '0;
      write_pixel    <= '0;
      write_en       <= 1'b0;
      write_finished <= 1'b0;
      frame_cnt      <= '0;
      err_cnt        <= '0;
    end else begin
      started_q      <= 1'b1;
      write_en       <= 1'b0;
      write_finished <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && pix_sof) begin
            write_x     <= '0;
            write_y     <= '0;
            write_pixel <= pix_data;
            write_en    <= 1'b1;
            x_q         <= XAfterOrigin;
            y_q         <= YAfterOrigin;
            if (SinglePixel) begin
              state_q       <= StSwapWait;
              rfe_pending_q <= read_frame_end;
            end else begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          if (accept) begin
            write_pixel <= pix_data;
            write_en    <= 1'b1;
            if (pix_sof && !at_origin) begin
              // Short frame: restart the raster, the frame is not committed.
              write_x <= '0;
              write_y <= '0;
              x_q     <= XAfterOrigin;
              y_q     <= YAfterOrigin;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
              write_x <= x_q;
              write_y <= y_q;
              if (at_last) begin
                state_q       <= StSwapWait;
                rfe_pending_q <= read_frame_end;
                x_q           <= '0;
                y_q           <= '0;
              end else begin
                x_q <= x_adv;
                y_q <= y_adv;
              end
            end
          end
        end
        StSwapWait: begin
          if (read_frame_end || rfe_pending_q) begin
            write_finished <= 1'b1;
            frame_cnt      <= frame_cnt + 16'd1;
            rfe_pending_q  <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FRAME_DROP_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if ((state_q == StSwapWait) && accept && pix_sof && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Bench for frame_write_sequencer with a 4x3 frame: raster table plus write scoreboard.
module tb_frame_write_sequencer;

  localparam int CW = 12;
  localparam int HS = 4;
  localparam int VS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic [11:0]   pix_data = '0;
  logic          pix_sof = 1'b0;
  logic          pix_ready;
  logic          read_frame_end = 1'b0;
  logic [CW-1:0] write_x;
  logic [CW-1:0] write_y;
  logic [11:0]   write_pixel;
  logic          write_en;
  logic          write_finished;
  logic [15:0]   frame_cnt;
  logic [7:0]    err_cnt;
  logic [7:0]    drop_cnt;

  frame_write_sequencer #(
    .COOR_WIDTH(CW),
    .HSIZE     (HS),
    .VSIZE     (VS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_ready     (pix_ready),
    .read_frame_end(read_frame_end),
    .write_x       (write_x),
    .write_y       (write_y),
    .write_pixel   (write_pixel),
    .write_en      (write_en),
    .write_finished(write_finished),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sof;
    int   data;
    int   x;
    int   y;
  } vec_t;

  typedef struct {
    int x;
    int y;
    int d;
  } exp_t;

  vec_t vec[HS*VS];
  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   n_we = 0;
  int   n_fin = 0;

`ifdef FRAME_DROP_EN
  localparam int ExpSwapReady = 1;
  localparam int ExpDrop = 1;
`else
  localparam int ExpSwapReady = 0;
  localparam int ExpDrop = 0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic sof, input int d, input int ex, input int ey);
    exp_t e;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = d[11:0];
    e.x = ex;
    e.y = ey;
    e.d = d;
    sb_q.push_back(e);
    tick();
  endtask

  task automatic run_frame(input int base, input bit toggle, input bit rfe_last);
    for (int i = 0; i < HS*VS; i++) begin
      if (toggle) begin
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        tick();
      end
      if (rfe_last && i == HS*VS-1) read_frame_end = 1'b1;
      drive_pix(vec[i].sof, base + vec[i].data, vec[i].x, vec[i].y);
      read_frame_end = 1'b0;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic pulse_rfe();
    read_frame_end = 1'b1;
    tick();
    read_frame_end = 1'b0;
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always begin
    @(posedge clk);
    #2;
    if (write_en) begin
      n_we++;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("write_x", int'(write_x), e.x);
        chk("write_y", int'(write_y), e.y);
        chk("write_pixel", int'(write_pixel), e.d);
      end
    end
    if (write_finished) begin
      n_fin++;
      chk("fin_with_write", int'(write_en), 0);
      chk("fin_pending_writes", sb_q.size(), 0);
    end
  end

  initial begin
    int we0;
    int fin0;

    for (int i = 0; i < HS*VS; i++) begin
      vec[i].sof  = (i == 0);
      vec[i].data = i + 1;
      vec[i].x    = i % HS;
      vec[i].y    = i / HS;
    end

    // Reset state
    tick();
    tick();
    chk("rst_ready", int'(pix_ready), 0);
    chk("rst_we", int'(write_en), 0);
    chk("rst_x", int'(write_x), 0);
    chk("rst_y", int'(write_y), 0);
    chk("rst_pix", int'(write_pixel), 0);
    chk("rst_fin", int'(write_finished), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    rst_n = 1'b1;
    chk("ready_before_clk", int'(pix_ready), 0);
    tick();
    chk("ready_idle", int'(pix_ready), 1);

    // Continuous frame 0x001..0x00C
    we0 = n_we;
    run_frame(0, 1'b0, 1'b0);
    tick();
    chk("frame1_writes", n_we - we0, 12);
    chk("swap_wait_ready", int'(pix_ready), ExpSwapReady);
    chk("frame1_no_fin", n_fin, 0);

    // Swap five cycles after the last pixel
    tick(); tick(); tick();
    pulse_rfe();
    chk("fin_high", int'(write_finished), 1);
    chk("frame_cnt_1", int'(frame_cnt), 1);
    tick();
    chk("fin_low", int'(write_finished), 0);
    chk("idle_ready", int'(pix_ready), 1);
    chk("fin_count_1", n_fin, 1);

    // Non-sof pixels discarded in idle, then a throttled frame
    we0 = n_we;
    pix_valid = 1'b1;
    pix_sof   = 1'b0;
    pix_data  = 12'h0AA;
    tick(); tick(); tick();
    pix_valid = 1'b0;
    tick();
    chk("idle_discard", n_we - we0, 0);
    run_frame(12'h040, 1'b1, 1'b0);
    tick();
    chk("toggle_writes", n_we - we0, 12);
    pulse_rfe();
    tick();
    chk("frame_cnt_2", int'(frame_cnt), 2);

    // Short frame: restart at (0,0); last pixel coincides with read_frame_end
    for (int i = 0; i < 6; i++) drive_pix(vec[i].sof, 12'h200 + vec[i].data, vec[i].x, vec[i].y);
    fin0 = n_fin;
    run_frame(12'h100, 1'b0, 1'b1);
    chk("err_cnt_1", int'(err_cnt), 1);
    chk("no_fin_with_last", int'(write_finished), 0);
    chk("no_early_fin", n_fin, fin0);
    tick();
    chk("fin_after_same_cycle_rfe", int'(write_finished), 1);
    tick();
    chk("fin_one_cycle", int'(write_finished), 0);
    chk("frame_cnt_3", int'(frame_cnt), 3);

    // New frame arrives while waiting to swap
    run_frame(12'h300, 1'b0, 1'b0);
    tick(); tick(); tick();
    fin0 = n_fin;
    we0 = n_we;
    pix_valid = 1'b1;
    pix_sof   = 1'b1;
    pix_data  = 12'h3FF;
    chk("held_ready", int'(pix_ready), ExpSwapReady);
    tick();
    pix_sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("held_ready", int'(pix_ready), ExpSwapReady);
      tick();
    end
    pix_valid = 1'b0;
    tick();
    chk("held_no_writes", n_we - we0, 0);
    chk("held_no_fin", n_fin, fin0);
    chk("drop_cnt", int'(drop_cnt), ExpDrop);
    pulse_rfe();
    chk("frame_cnt_4", int'(frame_cnt), 4);
    tick();

    // Reset mid-frame at pixel 7
    for (int i = 0; i < 7; i++) drive_pix(vec[i].sof, 12'h400 + vec[i].data, vec[i].x, vec[i].y);
    pix_valid = 1'b1;
    pix_data  = 12'h4FF;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", int'(write_en), 0);
    chk("mid_rst_x", int'(write_x), 0);
    chk("mid_rst_y", int'(write_y), 0);
    chk("mid_rst_pix", int'(write_pixel), 0);
    chk("mid_rst_ready", int'(pix_ready), 0);
    chk("mid_rst_frame_cnt", int'(frame_cnt), 0);
    sb_q.delete();
    pix_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    we0 = n_we;
    fin0 = n_fin;
    run_frame(12'h500, 1'b0, 1'b0);
    tick();
    chk("post_rst_writes", n_we - we0, 12);
    chk("post_rst_err_cnt", int'(err_cnt), 0);
    chk("post_rst_no_fin", n_fin, fin0);
    pulse_rfe();
    chk("post_rst_fin", int'(write_finished), 1);
    chk("post_rst_frame_cnt", int'(frame_cnt), 1);
    tick();
    chk("queue_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
